// File: rtl/afu_arb_pkg.sv
// Shared widths and mdata layout helpers for the SPL read-request arbiter.
package afu_arb_pkg;
   localparam int unsigned LINE_ADDR_W = 58;
   localparam int unsigned CACHE_WIDTH = 512;
   localparam int unsigned MDATA_MAX_W = 64;

   localparam int unsigned DEF_TAG_W   = 12;
   localparam int unsigned DEF_ID_W    = 1;
   localparam int unsigned DEF_MDATA_W = 14;

   // Field layout of mdata for the default two-requester, 12-bit-tag build.
   typedef struct packed {
      logic [DEF_MDATA_W-DEF_TAG_W-DEF_ID_W-1:0] pad;
      logic [DEF_ID_W-1:0]                       id;
      logic [DEF_TAG_W-1:0]                      tag;
   } arb_mdata_t;

   function automatic logic [MDATA_MAX_W-1:0] tag_mask(input int unsigned tag_w);
      return (MDATA_MAX_W'(1) << tag_w) - MDATA_MAX_W'(1);
   endfunction

   function automatic logic [MDATA_MAX_W-1:0] mdata_pack(input logic [MDATA_MAX_W-1:0] id,
                                                         input logic [MDATA_MAX_W-1:0] tag,
                                                         input int unsigned tag_w);
      return (id << tag_w) | (tag & tag_mask(tag_w));
   endfunction

   function automatic logic [MDATA_MAX_W-1:0] mdata_id(input logic [MDATA_MAX_W-1:0] md,
                                                       input int unsigned tag_w);
      return md >> tag_w;
   endfunction

   function automatic logic [MDATA_MAX_W-1:0] mdata_tag(input logic [MDATA_MAX_W-1:0] md,
                                                        input int unsigned tag_w);
      return md & tag_mask(tag_w);
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; the search starts at the pointer and wraps.
module rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i_req,
   input  logic         i_advance,
   output logic [N-1:0] o_grant_c
);
   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_ptr_nxt;
   logic [PTR_W-1:0] w_idx;

   // First requester at or above the pointer wins; pointer moves past the winner.
   always_comb begin
      o_grant_c = '0;
      w_ptr_nxt = r_ptr;
      w_idx     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_idx = PTR_W'((32'(r_ptr) + k) % N);
         if ((o_grant_c == '0) && i_req[w_idx]) begin
            o_grant_c[w_idx] = 1'b1;
            w_ptr_nxt        = PTR_W'((32'(w_idx) + 1) % N);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_ptr <= '0;
      else if (i_advance) r_ptr <= w_ptr_nxt;
   end
endmodule

// File: rtl/rd_req_arb.sv
// Shares the SPL read-request channel between NUM_REQ prefetchers, tags mdata
// with the requester id, steers responses back and enforces an outstanding cap.
module rd_req_arb
   import afu_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ         = 2,
   parameter int unsigned TAG_WIDTH       = 12,
   parameter int unsigned MDATA_WIDTH     = 14,
   parameter int unsigned MAX_OUTSTANDING = 64
) (
   input  logic                               clk,
   input  logic                               resetb,
   input  logic                               enable,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ*LINE_ADDR_W-1:0]     req_addr,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]       req_tag,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic                               almostfull,
   output logic                               rd_valid,
   output logic [LINE_ADDR_W-1:0]             rd_addr,
   output logic [MDATA_WIDTH-1:0]             rd_mdata,
   input  logic                               rsp_valid,
   input  logic [MDATA_WIDTH-1:0]             rsp_mdata,
   input  logic [CACHE_WIDTH-1:0]             rsp_data,
   output logic [NUM_REQ-1:0]                 out_valid,
   output logic [TAG_WIDTH-1:0]               out_tag,
   output logic [CACHE_WIDTH-1:0]             out_data,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
   output logic                               idle,
   output logic                               err
);
   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic                   r_af_q;
   logic                   r_rd_valid;
   logic [LINE_ADDR_W-1:0] r_rd_addr;
   logic [MDATA_WIDTH-1:0] r_rd_mdata;
   logic [NUM_REQ-1:0]     r_out_valid;
   logic [TAG_WIDTH-1:0]   r_out_tag;
   logic [CACHE_WIDTH-1:0] r_out_data;
   logic [OUT_W-1:0]       r_outstanding;
   logic                   r_err;

   logic [NUM_REQ-1:0]     w_grant;
   logic                   w_can_issue;
   logic                   w_accept;
   logic [OUT_W:0]         w_inflight;
   logic [ID_W-1:0]        w_gidx;
   logic [LINE_ADDR_W-1:0] w_sel_addr;
   logic [TAG_WIDTH-1:0]   w_sel_tag;
   logic [ID_W-1:0]        w_rsp_id;
   logic [TAG_WIDTH-1:0]   w_rsp_tag;
   logic                   w_rsp_ok;
   logic [OUT_W-1:0]       w_out_nxt;
   logic                   w_err_set;

   // A read still sitting in the rd_valid stage counts against the cap.
   assign w_inflight  = (OUT_W+1)'(r_outstanding) + (OUT_W+1)'(r_rd_valid);
   assign w_can_issue = enable && !r_af_q && (w_inflight < (OUT_W+1)'(MAX_OUTSTANDING));
   assign req_ready   = w_can_issue ? w_grant : '0;
   assign w_accept    = |(req_valid & req_ready);

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .clk       (clk),
      .rst       (resetb),
      .i_req     (req_valid),
      .i_advance (w_accept),
      .o_grant_c (w_grant)
   );

   always_comb begin
      w_gidx     = '0;
      w_sel_addr = '0;
      w_sel_tag  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_gidx     = ID_W'(i);
            w_sel_addr = req_addr[i*LINE_ADDR_W +: LINE_ADDR_W];
            w_sel_tag  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
         end
      end
   end

   assign w_rsp_id  = ID_W'(mdata_id(MDATA_MAX_W'(rsp_mdata), TAG_WIDTH));
   assign w_rsp_tag = TAG_WIDTH'(mdata_tag(MDATA_MAX_W'(rsp_mdata), TAG_WIDTH));
   assign w_rsp_ok  = (32'(w_rsp_id) < NUM_REQ);

   // Outstanding credit update; a response with nothing in flight is a protocol error.
   always_comb begin
      w_out_nxt = r_outstanding;
      w_err_set = rsp_valid && !w_rsp_ok;
      case ({r_rd_valid, rsp_valid})
         2'b10:   w_out_nxt = r_outstanding + OUT_W'(1);
         2'b01: begin
            if (r_outstanding == '0) w_err_set = 1'b1;
            else                     w_out_nxt = r_outstanding - OUT_W'(1);
         end
         default: w_out_nxt = r_outstanding;
      endcase
   end

   always_ff @(posedge clk or posedge resetb) begin
      if (resetb) begin
         r_af_q        <= 1'b1;
         r_rd_valid    <= 1'b0;
         r_rd_addr     <= '0;
         r_rd_mdata    <= '0;
         r_out_valid   <= '0;
         r_out_tag     <= '0;
         r_out_data    <= '0;
         r_outstanding <= '0;
         r_err         <= 1'b0;
      end else begin
         r_af_q        <= almostfull;
         r_rd_valid    <= w_accept;
         r_outstanding <= w_out_nxt;
         r_out_valid   <= '0;
         if (w_accept) begin
            r_rd_addr  <= w_sel_addr;
            r_rd_mdata <= MDATA_WIDTH'(mdata_pack(MDATA_MAX_W'(w_gidx),
                                                  MDATA_MAX_W'(w_sel_tag), TAG_WIDTH));
         end
         if (rsp_valid && w_rsp_ok) begin
            r_out_valid[w_rsp_id] <= 1'b1;
            r_out_tag             <= w_rsp_tag;
            r_out_data            <= rsp_data;
         end
         if (w_err_set) r_err <= 1'b1;
      end
   end

   assign rd_valid    = r_rd_valid;
   assign rd_addr     = r_rd_addr;
   assign rd_mdata    = r_rd_mdata;
   assign out_valid   = r_out_valid;
   assign out_tag     = r_out_tag;
   assign out_data    = r_out_data;
   assign outstanding = r_outstanding;
   assign err         = r_err;
   assign idle        = (r_outstanding == '0) && !r_rd_valid;
endmodule

// File: tb/tb_rd_req_arb.sv
// Directed + randomized bench for rd_req_arb against a behavioural model.
module tb_rd_req_arb;
   localparam int NR   = 3;
   localparam int TW   = 12;
   localparam int MW   = 14;
   localparam int MAXO = 4;
   localparam int AW   = 58;

   logic              clk = 1'b0;
   logic              resetb;
   logic              enable;
   logic [NR-1:0]     req_valid;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*TW-1:0]  req_tag;
   logic [NR-1:0]     req_ready;
   logic              almostfull;
   logic              rd_valid;
   logic [AW-1:0]     rd_addr;
   logic [MW-1:0]     rd_mdata;
   logic              rsp_valid;
   logic [MW-1:0]     rsp_mdata;
   logic [511:0]      rsp_data;
   logic [NR-1:0]     out_valid;
   logic [TW-1:0]     out_tag;
   logic [511:0]      out_data;
   logic [2:0]        outstanding;
   logic              idle;
   logic              err;

   rd_req_arb #(.NUM_REQ(NR), .TAG_WIDTH(TW), .MDATA_WIDTH(MW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .resetb(resetb), .enable(enable), .req_valid(req_valid),
      .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
      .almostfull(almostfull), .rd_valid(rd_valid), .rd_addr(rd_addr),
      .rd_mdata(rd_mdata), .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata),
      .rsp_data(rsp_data), .out_valid(out_valid), .out_tag(out_tag),
      .out_data(out_data), .outstanding(outstanding), .idle(idle), .err(err)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int n_rdv_obs = 0;

   // Behavioural model state
   int            m_ptr, m_out;
   bit            m_err, m_af_q, m_rd_valid;
   logic [AW-1:0] m_rd_addr;
   logic [MW-1:0] m_rd_mdata;
   logic [NR-1:0] m_out_valid;
   logic [TW-1:0] m_out_tag;
   logic [511:0]  m_out_data;
   logic [MW-1:0] inflight[$];
   logic [MW-1:0] saved[$];

   task automatic chk(input string t, input logic [511:0] o, input logic [511:0] e);
      n_total++;
      assert (o === e) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", t, o, e);
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_out = 0; m_err = 0; m_af_q = 1; m_rd_valid = 0;
      m_rd_addr = '0; m_rd_mdata = '0; m_out_valid = '0; m_out_tag = '0; m_out_data = '0;
      inflight.delete();
   endtask

   function automatic logic [NR-1:0] exp_ready();
      int idx;
      if (!enable || m_af_q || (m_out + int'(m_rd_valid)) >= MAXO) return '0;
      for (int k = 0; k < NR; k++) begin
         idx = (m_ptr + k) % NR;
         if (req_valid[idx]) return NR'(1 << idx);
      end
      return '0;
   endfunction

   task automatic model_update();
      logic [NR-1:0] er;
      int g, id;
      if (resetb) begin model_reset(); return; end
      er = exp_ready();
      g = -1;
      for (int i = 0; i < NR; i++) if (er[i] && req_valid[i]) g = i;
      if (m_rd_valid && rsp_valid) ;
      else if (m_rd_valid) m_out++;
      else if (rsp_valid) begin
         if (m_out == 0) m_err = 1; else m_out--;
      end
      if (m_rd_valid) inflight.push_back(m_rd_mdata);
      m_out_valid = '0;
      if (rsp_valid) begin
         id = (int'(rsp_mdata) >> TW) & 3;
         if (id < NR) begin
            m_out_valid = NR'(1 << id);
            m_out_tag   = rsp_mdata[TW-1:0];
            m_out_data  = rsp_data;
         end else m_err = 1;
      end
      m_rd_valid = (g >= 0);
      if (g >= 0) begin
         m_rd_addr  = req_addr[g*AW +: AW];
         m_rd_mdata = MW'((g << TW) | int'(req_tag[g*TW +: TW]));
         m_ptr      = (g + 1) % NR;
      end
      m_af_q = almostfull;
   endtask

   // One clock: check everything at the falling edge, advance the model at the rising edge.
   task automatic step();
      @(negedge clk);
      if (rd_valid === 1'b1) n_rdv_obs++;
      chk("req_ready", 512'(req_ready), 512'(exp_ready()));
      chk("rd_valid", 512'(rd_valid), 512'(m_rd_valid));
      chk("rd_addr", 512'(rd_addr), 512'(m_rd_addr));
      chk("rd_mdata", 512'(rd_mdata), 512'(m_rd_mdata));
      chk("out_valid", 512'(out_valid), 512'(m_out_valid));
      chk("out_tag", 512'(out_tag), 512'(m_out_tag));
      chk("out_data", out_data, m_out_data);
      chk("outstanding", 512'(outstanding), 512'(m_out));
      chk("err", 512'(err), 512'(m_err));
      chk("idle", 512'(idle), 512'((m_out == 0) && !m_rd_valid));
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic pick_rsp(input int pct);
      int i;
      rsp_valid = 1'b0;
      if (inflight.size() > 0 && $urandom_range(99) < pct) begin
         i = $urandom_range(inflight.size() - 1);
         rsp_mdata = inflight[i];
         inflight.delete(i);
         rsp_data  = rand512();
         rsp_valid = 1'b1;
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [TW-1:0] t);
      req_addr[i*AW +: AW] = a;
      req_tag[i*TW +: TW]  = t;
   endtask

   initial begin
      int n0;
      logic [511:0] pat;
      resetb = 1'b1; enable = 1'b0; req_valid = '0; req_addr = '0; req_tag = '0;
      almostfull = 1'b0; rsp_valid = 1'b0; rsp_mdata = '0; rsp_data = '0;
      model_reset();
      #1;
      step(); step();
      resetb = 1'b0;

      // Two requesters streaming: grants alternate
      enable = 1'b1; req_valid = 3'b011;
      set_req(0, 58'h0AAA0, 12'h011); set_req(1, 58'h0BBB0, 12'h022); set_req(2, 58'h0CCC0, 12'h033);
      for (int c = 0; c < 12; c++) begin pick_rsp(100); step(); end

      // Drain, then a lone request from requester 1
      req_valid = '0;
      for (int c = 0; c < 8; c++) begin pick_rsp(100); step(); end
      rsp_valid = 1'b0;
      set_req(1, 58'h100, 12'h005); req_valid = 3'b010;
      step();
      req_valid = '0;
      step();
      chk("lone_rd_addr", 512'(rd_addr), 512'(58'h100));
      chk("lone_rd_mdata", 512'(rd_mdata), 512'(14'h1005));
      for (int c = 0; c < 4; c++) begin pick_rsp(100); step(); end

      // almostfull pulse during streaming
      req_valid = 3'b011;
      for (int c = 0; c < 4; c++) begin pick_rsp(100); step(); end
      almostfull = 1'b1;
      for (int c = 0; c < 4; c++) begin pick_rsp(100); step(); end
      almostfull = 1'b0;
      for (int c = 0; c < 5; c++) begin pick_rsp(100); step(); end

      // Credit limit: no responses, exactly MAXO issues, then one more per response
      req_valid = '0;
      for (int c = 0; c < 10; c++) begin pick_rsp(100); step(); end
      rsp_valid = 1'b0;
      n0 = n_rdv_obs;
      req_valid = 3'b111;
      for (int c = 0; c < 10; c++) step();
      chk("cap_issues", 512'(n_rdv_obs - n0), 512'(MAXO));
      chk("cap_outstanding", 512'(outstanding), 512'(MAXO));
      pick_rsp(100); step(); rsp_valid = 1'b0;
      for (int c = 0; c < 5; c++) step();
      chk("cap_issues_plus1", 512'(n_rdv_obs - n0), 512'(MAXO + 1));

      // Response routing with a fixed mdata
      req_valid = '0;
      void'(inflight.pop_front());
      pat = rand512();
      rsp_valid = 1'b1; rsp_mdata = 14'h0ABC; rsp_data = pat;
      step();
      rsp_valid = 1'b0;
      chk("rsp_out_valid", 512'(out_valid), 512'(3'b001));
      chk("rsp_out_tag", 512'(out_tag), 512'(12'hABC));
      chk("rsp_out_data", out_data, pat);

      // Issue and response in the same cycle leave outstanding unchanged
      req_valid = 3'b001;
      step();
      req_valid = '0;
      pick_rsp(100);
      step();
      rsp_valid = 1'b0;
      chk("simul_outstanding", 512'(outstanding), 512'(MAXO - 1));

      // Invalid id drops the response and sets sticky err
      void'(inflight.pop_front());
      rsp_valid = 1'b1; rsp_mdata = 14'h3123; rsp_data = rand512();
      step();
      rsp_valid = 1'b0;
      chk("badid_out_valid", 512'(out_valid), 512'(0));
      chk("badid_err", 512'(err), 512'(1));
      step(); step();
      chk("err_sticky", 512'(err), 512'(1));

      // Reset mid-flight; a late response then flags err
      saved = inflight;
      resetb = 1'b1; model_reset();
      step(); step();
      resetb = 1'b0;
      step();
      chk("reset_err_clear", 512'(err), 512'(0));
      chk("reset_outstanding", 512'(outstanding), 512'(0));
      rsp_valid = 1'b1; rsp_mdata = saved[0]; rsp_data = rand512();
      step();
      rsp_valid = 1'b0;
      chk("late_rsp_err", 512'(err), 512'(1));
      step();
      resetb = 1'b1; model_reset();
      step();
      resetb = 1'b0;
      step();

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         req_valid  = NR'($urandom);
         for (int i = 0; i < NR; i++) set_req(i, AW'({$urandom, $urandom}), TW'($urandom));
         almostfull = ($urandom_range(7) == 0);
         enable     = ($urandom_range(15) != 0);
         pick_rsp(55);
         step();
      end

      // Drain to idle with enable low
      req_valid = '0; almostfull = 1'b0; enable = 1'b0;
      for (int c = 0; c < 12; c++) begin pick_rsp(100); step(); end
      rsp_valid = 1'b0;
      step();
      chk("final_idle", 512'(idle), 512'(1));
      chk("final_outstanding", 512'(outstanding), 512'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
